// File: rtl/sta_sto_seq.sv
// I2C START/STOP timing sequencer: two P-cycle phases per condition, outputs one cycle after the accepting edge.
// No backpressure: requests arriving while busy (or a STOP colliding with a START) are dropped and flagged on req_err.
module sta_sto_seq #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  start_req,
  input  logic                  stop_req,
  output logic                  gen_sta,
  output logic                  gen_sto,
  output logic                  scl_gen_comp_match,
  output logic                  busy,
  output logic                  done,
  output logic                  bus_owned,
  output logic                  req_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] STA_HOLD  = 3'd1;
  localparam logic [2:0] STA_LOW   = 3'd2;
  localparam logic [2:0] STO_SETUP = 3'd3;
  localparam logic [2:0] STO_FREE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [PRESCALE_W-1:0] p_new;
  logic                  expire;
  logic                  owned_q, owned_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  gen_sta_q, gen_sto_q, comp_q, busy_q;

  assign p_new  = (prescale == '0) ? PRESCALE_W'(1) : prescale;
  assign expire = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    owned_d = owned_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // START has priority; a simultaneous STOP is dropped and flagged
        if (start_req) begin
          p_d     = p_new;
          cnt_d   = p_new - PRESCALE_W'(1);
          state_d = STA_HOLD;
          owned_d = 1'b1;
          err_d   = stop_req;
        end else if (stop_req) begin
          p_d     = p_new;
          cnt_d   = p_new - PRESCALE_W'(1);
          state_d = STO_SETUP;
        end
      end
      STA_HOLD, STA_LOW, STO_SETUP, STO_FREE: begin
        err_d = start_req | stop_req;
        if (expire) begin
          cnt_d = p_q - PRESCALE_W'(1);
          case (state_q)
            STA_HOLD:  state_d = STA_LOW;
            STO_SETUP: state_d = STO_FREE;
            STO_FREE: begin
              state_d = IDLE;
              done_d  = 1'b1;
              owned_d = 1'b0;
            end
            default: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q - PRESCALE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= PRESCALE_W'(1);
      owned_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      gen_sta_q <= 1'b0;
      gen_sto_q <= 1'b0;
      comp_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      owned_q   <= owned_d;
      done_q    <= done_d;
      err_q     <= err_d;
      gen_sta_q <= (state_d == STA_HOLD) || (state_d == STA_LOW);
      gen_sto_q <= (state_d == STO_SETUP) || (state_d == STO_FREE);
      comp_q    <= (state_d == STA_LOW) || (state_d == STO_FREE);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign gen_sta            = gen_sta_q;
  assign gen_sto            = gen_sto_q;
  assign scl_gen_comp_match = comp_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign bus_owned          = owned_q;
  assign req_err            = err_q;

endmodule

// File: tb/tb_sta_sto_seq.sv
// Scoreboarded bench for sta_sto_seq: a condition-level model predicts each cycle's outputs.
module tb_sta_sto_seq;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [15:0] prescale = '0;
  logic        start_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        gen_sta, gen_sto, scl_gen_comp_match, busy, done, bus_owned, req_err;

  int checks = 0;
  int errors = 0;

  // Expected {gen_sta, gen_sto, comp, busy, done, bus_owned, req_err} per clock edge
  logic [6:0] exp_q[$];

  // Model state: condition kind (0 none, 1 START, 2 STOP), cycle index inside it, latched length
  int m_kind = 0;
  int m_el   = 0;
  int m_p    = 1;
  bit m_owned = 1'b0;

  sta_sto_seq #(.PRESCALE_W(16)) dut (
    .pclk(pclk), .preset(preset), .prescale(prescale),
    .start_req(start_req), .stop_req(stop_req),
    .gen_sta(gen_sta), .gen_sto(gen_sto), .scl_gen_comp_match(scl_gen_comp_match),
    .busy(busy), .done(done), .bus_owned(bus_owned), .req_err(req_err)
  );

  always #5 pclk = ~pclk;

  task automatic model_step(input bit s, input bit t, input int ps, input bit r);
    bit d_n, e_n, was_busy;
    logic [6:0] e;
    d_n = 1'b0;
    e_n = 1'b0;
    if (r) begin
      m_kind = 0; m_el = 0; m_owned = 1'b0;
    end else begin
      was_busy = (m_kind != 0);
      e_n = was_busy ? (s | t) : (s & t);
      if (was_busy) begin
        m_el++;
        if (m_el == 2 * m_p) begin
          d_n = 1'b1;
          if (m_kind == 2) m_owned = 1'b0;
          m_kind = 0;
        end
      end else if (s | t) begin
        m_p = (ps == 0) ? 1 : ps;
        m_el = 0;
        m_kind = s ? 1 : 2;
        if (s) m_owned = 1'b1;
      end
    end
    e = {m_kind == 1, m_kind == 2, (m_kind != 0) && (m_el >= m_p), m_kind != 0,
         d_n, m_owned, e_n};
    exp_q.push_back(e);
  endtask

  task automatic step(input bit s, input bit t, input int ps, input bit r);
    preset = r;
    start_req = s;
    stop_req = t;
    prescale = 16'(ps);
    model_step(s, t, ps, r);
    @(posedge pclk);
    #1;
    start_req = 1'b0;
    stop_req = 1'b0;
  endtask

  task automatic idle(input int n, input int ps);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ps, 1'b0);
  endtask

  // Asynchronous reset between edges, after the monitor has sampled this cycle
  task automatic async_reset_mid();
    logic [6:0] got;
    #4;
    preset = 1'b1;
    #1;
    got = {gen_sta, gen_sto, scl_gen_comp_match, busy, done, bus_owned, req_err};
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL async_reset outputs got=%b want=%b at %0t", got, 7'b0, $time);
    end
    m_kind = 0; m_el = 0; m_owned = 1'b0;
  endtask

  initial begin : monitor
    logic [6:0] got, want;
    forever begin
      @(posedge pclk);
      #3;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = {gen_sta, gen_sto, scl_gen_comp_match, busy, done, bus_owned, req_err};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL cycle_outputs {sta,sto,comp,busy,done,own,err} got=%b want=%b at %0t",
                   got, want, $time);
        end
        if (gen_sta && gen_sto) begin
          errors++;
          $display("FAIL sta_sto_exclusive got=11 want=not both at %0t", $time);
        end
      end
    end
  end

  initial begin : stim
    #1;
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    idle(2, 0);
    // START P=4, then STOP P=3
    step(1'b1, 1'b0, 4, 1'b0);
    idle(10, 4);
    step(1'b0, 1'b1, 3, 1'b0);
    idle(8, 3);
    // prescale 0 behaves as 1
    step(1'b1, 1'b0, 0, 1'b0);
    idle(3, 0);
    // simultaneous requests: START wins
    step(1'b1, 1'b1, 2, 1'b0);
    idle(6, 2);
    // STOP while busy and prescale changed mid-START
    step(1'b1, 1'b0, 4, 1'b0);
    step(1'b0, 1'b0, 10, 1'b0);
    step(1'b0, 1'b1, 10, 1'b0);
    idle(8, 10);
    // reset during STO_SETUP
    step(1'b0, 1'b1, 5, 1'b0);
    step(1'b0, 1'b0, 5, 1'b0);
    async_reset_mid();
    step(1'b0, 1'b0, 5, 1'b1);
    step(1'b0, 1'b0, 5, 1'b1);
    step(1'b1, 1'b0, 2, 1'b0);
    idle(6, 2);
    // randomized traffic, including requests on the done cycle and while busy
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 5)), 1'b0);
    end
    idle(12, 0);
    @(posedge pclk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sta_sto_seq.md
# sta_sto_seq

Timing sequencer for I2C START and STOP conditions in the APB I2C master. It accepts single-cycle start/stop requests from the command/register logic and times each condition with a programmable prescaler. It drives `gen_sta`, `gen_sto` and `scl_gen_comp_match` into the combinational start/stop SDA/SCL generator directly downstream. It also tracks bus ownership between a START and its closing STOP.

## Interface
- `PRESCALE_W`, default 16: width of the phase-length prescaler.
- `pclk` in 1: system clock; all state changes on its rising edge.
- `preset` in 1: asynchronous, active-high reset.
- `prescale` in PRESCALE_W: phase length in pclk cycles. The value 0 is treated as 1.
- `start_req` in 1: single-cycle pulse requesting a START or repeated START.
- `stop_req` in 1: single-cycle pulse requesting a STOP.
- `gen_sta` out 1: START condition active; goes to the downstream generator.
- `gen_sto` out 1: STOP condition active; goes to the downstream generator.
- `scl_gen_comp_match` out 1: second-phase marker; goes to the downstream generator.
- `busy` out 1: sequencer not idle.
- `done` out 1: one-cycle pulse when a condition completes.
- `bus_owned` out 1: high from the start of a START until the end of a STOP.
- `req_err` out 1: one-cycle pulse when a request is dropped.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE, counter to 0, latched prescale to 1.
- States: IDLE, STA_HOLD, STA_LOW, STO_SETUP, STO_FREE.
- Outputs by state (downstream effect in brackets):
  - IDLE: gen_sta=0, gen_sto=0, comp=0.
  - STA_HOLD: gen_sta=1, comp=0 [SDA low, SCL high].
  - STA_LOW: gen_sta=1, comp=1 [SDA low, SCL low].
  - STO_SETUP: gen_sto=1, comp=0 [SDA low, SCL high].
  - STO_FREE: gen_sto=1, comp=1 [SDA high, SCL high].
- `gen_sta` and `gen_sto` are never high together.
- Request acceptance in IDLE:
  - On `start_req`: latch P = max(prescale,1), load the counter, go to STA_HOLD.
  - On `stop_req`: latch P the same way, load the counter, go to STO_SETUP.
  - STOP is accepted even when `bus_owned`=0, for bus recovery.
- Transitions when the phase counter expires:
  - STA_HOLD → STA_LOW.
  - STA_LOW → IDLE.
  - STO_SETUP → STO_FREE.
  - STO_FREE → IDLE.
- Each non-IDLE state lasts exactly P cycles.
- The counter decrements by 1 per cycle. A phase ends when the counter reaches 0, and the counter reloads P-1 on the phase transition.
- P is latched once per condition. Changes to `prescale` mid-condition are ignored.
- `bus_owned`:
  - Set on entry to STA_HOLD.
  - Cleared on the STO_FREE → IDLE transition.
  - A repeated START (start_req in IDLE while owned) keeps it set.
- `done` pulses in the first IDLE cycle after STA_LOW or STO_FREE completes.
- `busy` = state ≠ IDLE.
- Conflicts:
  - `start_req` and `stop_req` in the same IDLE cycle: START wins, STOP is dropped, `req_err` pulses on the next cycle.
  - Any request while busy is dropped, with `req_err` on the next cycle. The active condition is unaffected.
  - A request arriving in the same cycle as `done` is accepted, because the state is already IDLE.
- Asynchronous reset mid-condition: all outputs drop to 0 immediately, `bus_owned` clears, and no `done` is produced.

## Timing
- Request sampled high at edge N (IDLE) → `gen_sta` or `gen_sto` high from cycle N+1. Zero-cycle decision, one-cycle registered latency.
- START timeline:
  - STA_HOLD covers cycles N+1..N+P.
  - STA_LOW covers cycles N+P+1..N+2P.
  - Cycle N+2P+1: all outputs 0, `done`=1, `busy`=0.
- STOP timeline: same shape with STO_SETUP then STO_FREE. `bus_owned` is 0 from cycle N+2P+1.
- Total condition length is 2P cycles. The earliest next request edge is N+2P+1, giving 2P+1 cycles per back-to-back condition.
- `req_err` and `done` are each exactly one cycle wide.

## Test plan
- Reset then idle: all outputs 0. Pulse `start_req` with prescale=4 → `gen_sta` high for 8 cycles, `scl_gen_comp_match` high in cycles 5-8, `done` in cycle 9, `bus_owned`=1.
- After that START, `stop_req` with prescale=3 → `gen_sto` 6 cycles, comp high in cycles 4-6, `done` in cycle 7, `bus_owned` drops with `done`.
- prescale=0 → each phase lasts 1 cycle. START completes in 2 cycles, `done` in cycle 3.
- `start_req` and `stop_req` in the same cycle → START sequence runs, `req_err` pulses in cycle +1, no STOP follows.
- `stop_req` at cycle 2 of a START, and `prescale` changed mid-START from 4 to 10 → `req_err` pulses, START still totals 8 cycles.
- Assert `preset` in STO_SETUP → all outputs 0 asynchronously, no `done`. After release, `start_req` behaves as from a fresh reset.
